// File: rtl/output_argmax_judge.sv
// Sequential argmax judge: joins an output vector with its label, scans one element
// per cycle, reports {correct, index}, keeps saturating accuracy counters.
// Optional best-minus-second margin output: define OUTPUT_ARGMAX_JUDGE_MARGIN_EN.
module output_argmax_judge #(
  parameter int NP   = 7,
  parameter int NC   = 6,
  parameter int WF   = 5,
  parameter int WCNT = 16,
  localparam int WO  = $clog2(NP) + WF,
  localparam int LW  = $clog2(NC)
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iClear,
  input  logic               iValid_AS_Output,
  output logic               oReady_AS_Output,
  input  logic [NC*WO-1:0]   iData_AS_Output,
  input  logic               iValid_AS_Label,
  output logic               oReady_AS_Label,
  input  logic [LW-1:0]      iData_AS_Label,
  output logic               oValid_BM_Result,
  input  logic               iReady_BM_Result,
  output logic [LW:0]        oData_BM_Result,
  output logic [WCNT-1:0]    oCount_Total,
  output logic [WCNT-1:0]    oCount_Correct
`ifdef OUTPUT_ARGMAX_JUDGE_MARGIN_EN
  ,
  output logic [WO:0]        oData_BM_Margin
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;

  state_t state, stateNext;

  logic [NC*WO-1:0]      vecReg;
  logic [LW-1:0]         labelReg;
  logic [LW-1:0]         bestIdx;
  logic signed [WO-1:0]  bestVal;
  logic [LW-1:0]         k;
  logic signed [WO-1:0]  elemK;
  logic                  accept;
  logic                  resultHs;
  logic                  lastElem;
  logic                  correctFlag;

  assign accept   = (state == IDLE) && iValid_AS_Output && iValid_AS_Label;
  assign resultHs = (state == RESULT) && iReady_BM_Result;
  assign lastElem = (k == LW'(NC - 1));
  assign elemK    = $signed(vecReg[int'(k)*WO +: WO]);
  // bestIdx never exceeds NC-1, so an out-of-range label can never match.
  assign correctFlag = (labelReg == bestIdx);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the comb processes use blocking assignments.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:   if (accept)   stateNext = SCAN;
      SCAN:   if (lastElem) stateNext = RESULT;
      RESULT: if (resultHs) stateNext = IDLE;
      default:              stateNext = IDLE;
    endcase
  end

`ifdef OUTPUT_ARGMAX_JUDGE_MARGIN_EN
  logic signed [WO-1:0] secondVal;
  logic [WO:0]          marginRaw;

  // best >= second always holds, so the sign-extended difference is non-negative.
  assign marginRaw = {bestVal[WO-1], bestVal} - {secondVal[WO-1], secondVal};
`endif

  // NOTE: every comb output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    oReady_AS_Output = 1'b0;
    oReady_AS_Label  = 1'b0;
    oValid_BM_Result = 1'b0;
    oData_BM_Result  = '0;
`ifdef OUTPUT_ARGMAX_JUDGE_MARGIN_EN
    oData_BM_Margin  = '0;
`endif
    if (accept) begin
      oReady_AS_Output = 1'b1;
      oReady_AS_Label  = 1'b1;
    end
    if (state == RESULT) begin
      oValid_BM_Result = 1'b1;
      oData_BM_Result  = {correctFlag, bestIdx};
`ifdef OUTPUT_ARGMAX_JUDGE_MARGIN_EN
      oData_BM_Margin  = marginRaw;
`endif
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      vecReg   <= '0;
      labelReg <= '0;
      bestIdx  <= '0;
      bestVal  <= '0;
      k        <= '0;
    end else if (accept) begin
      vecReg   <= iData_AS_Output;
      labelReg <= iData_AS_Label;
      bestIdx  <= '0;
      bestVal  <= $signed(iData_AS_Output[WO-1:0]);
      k        <= LW'(1);
    end else if (state == SCAN) begin
      // Strictly greater: ties keep the lowest index.
      if (elemK > bestVal) begin
        bestIdx <= k;
        bestVal <= elemK;
      end
      if (!lastElem) k <= k + LW'(1);
    end
  end

`ifdef OUTPUT_ARGMAX_JUDGE_MARGIN_EN
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      secondVal <= '0;
    end else if (accept) begin
      secondVal <= $signed(iData_AS_Output[WO-1:0]);
    end else if (state == SCAN) begin
      // At k==1 the runner-up is seeded unconditionally with whichever loses.
      if (elemK > bestVal)
        secondVal <= bestVal;
      else if ((k == LW'(1)) || (elemK > secondVal))
        secondVal <= elemK;
    end
  end
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oCount_Total   <= '0;
      oCount_Correct <= '0;
    end else if (iClear) begin
      oCount_Total   <= '0;
      oCount_Correct <= '0;
    end else if (resultHs) begin
      if (oCount_Total != '1)                  oCount_Total   <= oCount_Total + WCNT'(1);
      if (correctFlag && oCount_Correct != '1) oCount_Correct <= oCount_Correct + WCNT'(1);
    end
  end

endmodule

// File: tb/tb_output_argmax_judge.sv
// Scoreboard bench for output_argmax_judge: directed vectors with hand-computed
// results; a negedge monitor pops and compares every delivered result.
module tb_output_argmax_judge;

  localparam int NC   = 6;
  localparam int WO   = 8;
  localparam int LW   = 3;
  localparam int CMAX = 15;

  typedef struct {
    logic [LW:0] data;
    logic [WO:0] margin;
  } exp_t;

  logic            iCLK = 1'b0;
  logic            iRST;
  logic            iClear;
  logic            iValid_AS_Output;
  logic            oReady_AS_Output;
  logic [NC*WO-1:0] iData_AS_Output;
  logic            iValid_AS_Label;
  logic            oReady_AS_Label;
  logic [LW-1:0]   iData_AS_Label;
  logic            oValid_BM_Result;
  logic            iReady_BM_Result;
  logic [LW:0]     oData_BM_Result;
  logic [3:0]      oCount_Total;
  logic [3:0]      oCount_Correct;
`ifdef OUTPUT_ARGMAX_JUDGE_MARGIN_EN
  logic [WO:0]     oData_BM_Margin;
`endif

  output_argmax_judge #(.NP(7), .NC(NC), .WF(5), .WCNT(4)) dut (
    .iCLK             (iCLK),
    .iRST             (iRST),
    .iClear           (iClear),
    .iValid_AS_Output (iValid_AS_Output),
    .oReady_AS_Output (oReady_AS_Output),
    .iData_AS_Output  (iData_AS_Output),
    .iValid_AS_Label  (iValid_AS_Label),
    .oReady_AS_Label  (oReady_AS_Label),
    .iData_AS_Label   (iData_AS_Label),
    .oValid_BM_Result (oValid_BM_Result),
    .iReady_BM_Result (iReady_BM_Result),
    .oData_BM_Result  (oData_BM_Result),
    .oCount_Total     (oCount_Total),
    .oCount_Correct   (oCount_Correct)
`ifdef OUTPUT_ARGMAX_JUDGE_MARGIN_EN
    ,
    .oData_BM_Margin  (oData_BM_Margin)
`endif
  );

  always #5 iCLK = ~iCLK;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  int   mTotal = 0;
  int   mCorrect = 0;
  time  capTime;
  time  prevCap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NC*WO-1:0] mk(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5);
    return {8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic checkCounts(input string name);
    check({name, "_total"},   32'(oCount_Total),   32'(mTotal));
    check({name, "_correct"}, 32'(oCount_Correct), 32'(mCorrect));
  endtask

  // Monitor: pops on each handshake, checks data stays held under backpressure.
  logic        held = 1'b0;
  logic [LW:0] hData;
  logic [WO:0] hMargin;
  exp_t        e;

  always @(negedge iCLK) begin
    if (iRST) begin
      held = 1'b0;
    end else if (oValid_BM_Result) begin
      if (held) begin
        check("hold_data", 32'(oData_BM_Result), 32'(hData));
`ifdef OUTPUT_ARGMAX_JUDGE_MARGIN_EN
        check("hold_margin", 32'(oData_BM_Margin), 32'(hMargin));
`endif
      end
      if (iReady_BM_Result) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(oData_BM_Result), 32'hdead);
        end else begin
          e = sb.pop_front();
          check("result_data", 32'(oData_BM_Result), 32'(e.data));
`ifdef OUTPUT_ARGMAX_JUDGE_MARGIN_EN
          check("result_margin", 32'(oData_BM_Margin), 32'(e.margin));
`endif
        end
        held = 1'b0;
      end else begin
        held  = 1'b1;
        hData = oData_BM_Result;
`ifdef OUTPUT_ARGMAX_JUDGE_MARGIN_EN
        hMargin = oData_BM_Margin;
`endif
      end
    end else begin
      held = 1'b0;
    end
  end

  // Called just after a posedge; returns just after the capture edge.
  task automatic doCapture(input logic [NC*WO-1:0] vec, input logic [LW-1:0] lbl,
                           input int outputFirst, input bit push,
                           input logic [LW:0] expData, input logic [WO:0] expMargin);
    bit   got;
    exp_t x;
    iData_AS_Output = vec;
    iData_AS_Label  = lbl;
    if (outputFirst > 0) begin
      iValid_AS_Output = 1'b1;
      iValid_AS_Label  = 1'b0;
      repeat (outputFirst) begin
        @(negedge iCLK);
        check("join_alone_rdy_out", 32'(oReady_AS_Output), 32'd0);
        check("join_alone_rdy_lbl", 32'(oReady_AS_Label), 32'd0);
      end
      @(posedge iCLK); #1;
    end
    iValid_AS_Output = 1'b1;
    iValid_AS_Label  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge iCLK);
      if (oReady_AS_Output && oReady_AS_Label) begin
        got = 1'b1;
        break;
      end
    end
    check("capture_seen", 32'(got), 32'd1);
    @(posedge iCLK);
    capTime = $time;
    if (push) begin
      x.data   = expData;
      x.margin = expMargin;
      sb.push_back(x);
    end
    #1;
    iValid_AS_Output = 1'b0;
    iValid_AS_Label  = 1'b0;
    iData_AS_Output  = 48'({$urandom(), $urandom()});
    iData_AS_Label   = 3'($urandom());
  endtask

  task automatic sendSample(input logic [NC*WO-1:0] vec, input logic [LW-1:0] lbl,
                            input logic [LW:0] expData, input logic [WO:0] expMargin,
                            input int outputFirst, input int readyDelay, input bit clearAtHs);
    int cnt;
    bit seen;
    iReady_BM_Result = (readyDelay == 0);
    doCapture(vec, lbl, outputFirst, 1'b1, expData, expMargin);
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge iCLK); cnt++; #1;
      if (oValid_BM_Result) begin
        seen = 1'b1;
        break;
      end
    end
    check("result_latency", 32'(cnt), 32'(NC - 1));
    repeat (readyDelay) begin
      checkCounts("backpressure_cnt");
      @(posedge iCLK); #1;
    end
    if (clearAtHs) iClear = 1'b1;
    iReady_BM_Result = 1'b1;
    @(posedge iCLK); #1;
    iClear           = 1'b0;
    iReady_BM_Result = 1'b0;
    if (clearAtHs) begin
      mTotal   = 0;
      mCorrect = 0;
    end else begin
      if (mTotal != CMAX) mTotal++;
      if (expData[LW] && mCorrect != CMAX) mCorrect++;
    end
    checkCounts("after_hs");
    check("valid_drop_after_hs", 32'(oValid_BM_Result), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRST = 1'b1; iClear = 1'b0;
    iValid_AS_Output = 1'b0; iValid_AS_Label = 1'b0; iReady_BM_Result = 1'b0;
    iData_AS_Output = '0; iData_AS_Label = '0;
    repeat (3) @(posedge iCLK);
    #1;
    check("rst_valid", 32'(oValid_BM_Result), 32'd0);
    check("rst_data",  32'(oData_BM_Result),  32'd0);
    check("rst_rdy_out", 32'(oReady_AS_Output), 32'd0);
    checkCounts("rst");
    iRST = 1'b0;
    @(posedge iCLK); #1;

    // Tie at index 4 keeps index 2; label matches.
    sendSample(mk(10, -3, 45, 7, 45, 0), 3'd2, 4'hA, 9'd0, 0, 0, 1'b0);
    // Negative values, wrong prediction.
    sendSample(mk(-128, -128, -128, -128, -128, -1), 3'd0, 4'h5, 9'd127, 0, 0, 1'b0);
    // Output valid alone for 3 cycles, then 4 cycles of result backpressure.
    sendSample(mk(1, 2, 3, 4, 5, 6), 3'd5, 4'hD, 9'd1, 3, 4, 1'b0);
    sendSample(mk(127, -128, 0, 0, 0, 126), 3'd0, 4'h8, 9'd1, 0, 0, 1'b0);
    sendSample(mk(-128, 127, -128, -128, -128, -128), 3'd1, 4'h9, 9'd255, 0, 0, 1'b0);
    sendSample(mk(-1, -2, -3, -4, -5, -6), 3'd0, 4'h8, 9'd1, 0, 0, 1'b0);

    // Out-of-range label, back-to-back throughput.
    sendSample(mk(-5, -5, 20, -5, -5, -5), 3'd7, 4'h2, 9'd25, 0, 0, 1'b0);
    prevCap = capTime;
    sendSample(mk(0, 0, 0, 0, 0, 0), 3'd7, 4'h0, 9'd0, 0, 0, 1'b0);
    check("throughput", 32'(capTime - prevCap), 32'((NC + 1) * 10));

    // Clear coincident with a correct handshake wins.
    sendSample(mk(10, -3, 45, 7, 45, 0), 3'd2, 4'hA, 9'd0, 0, 0, 1'b1);

    // Saturation at 4-bit counters.
    for (int i = 0; i < 16; i++)
      sendSample(mk(1, 2, 3, 4, 5, 6), 3'd5, 4'hD, 9'd1, 0, 0, 1'b0);
    check("sat_total", 32'(oCount_Total), 32'd15);
    iClear = 1'b1;
    @(posedge iCLK); #1;
    iClear = 1'b0;
    mTotal = 0; mCorrect = 0;
    checkCounts("clear_pulse");

    // Reset mid-SCAN: sample aborted, nothing counted.
    sendSample(mk(-1, -2, -3, -4, -5, -6), 3'd0, 4'h8, 9'd1, 0, 0, 1'b0);
    iReady_BM_Result = 1'b1;
    doCapture(mk(3, 9, 1, 1, 1, 1), 3'd1, 0, 1'b0, 4'h0, 9'd0);
    @(posedge iCLK); @(posedge iCLK); #1;
    iRST = 1'b1;
    #1;
    mTotal = 0; mCorrect = 0;
    check("rst_scan_valid", 32'(oValid_BM_Result), 32'd0);
    checkCounts("rst_scan");
    @(posedge iCLK); #1;
    iRST = 1'b0;
    repeat (8) @(posedge iCLK);
    #1;
    checkCounts("rst_scan_nocount");
    sendSample(mk(-128, -128, -128, -128, -128, -1), 3'd0, 4'h5, 9'd127, 0, 0, 1'b0);

    // Reset mid-RESULT: valid drops asynchronously.
    iReady_BM_Result = 1'b0;
    doCapture(mk(3, 9, 1, 1, 1, 1), 3'd1, 0, 1'b0, 4'h0, 9'd0);
    repeat (NC) @(posedge iCLK);
    #1;
    check("result_pending", 32'(oValid_BM_Result), 32'd1);
    #2;
    iRST = 1'b1;
    #1;
    mTotal = 0; mCorrect = 0;
    check("rst_result_valid", 32'(oValid_BM_Result), 32'd0);
    check("rst_result_data",  32'(oData_BM_Result),  32'd0);
    checkCounts("rst_result");
    @(posedge iCLK); #1;
    iRST = 1'b0;
    @(posedge iCLK); #1;
    sendSample(mk(10, -3, 45, 7, 45, 0), 3'd2, 4'hA, 9'd0, 0, 0, 1'b0);

    repeat (3) @(posedge iCLK);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
